// File: rtl/truth_table_scanner.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_scanner
// Description : Drives every input combination of an N_IN-input Boolean
//               function onto vec_o, holds each one for SETTLE+1 cycles and
//               captures two candidate implementations (s_a, s_b) into
//               truth-table words. On completion it reports whether the two
//               tables agree and the lowest index at which they first differ.
//
// Ports       : clk            - rising-edge clock
//               reset          - asynchronous, active-high reset
//               start          - scan request, honoured only while idle
//               vec_o          - function input vector (MSB = first variable)
//               s_a, s_b       - outputs of the two implementations
//               table_a/b      - captured truth tables, bit i <=> vec_o == i
//               busy           - high for the whole scan
//               done           - one-cycle completion pulse
//               equal          - table_a == table_b (valid from done)
//               mismatch_valid - at least one index differs
//               first_mismatch - lowest differing index (0 if none)
//
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_scanner #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic [N_IN-1:0]        vec_o,
    input  logic                   s_a,
    input  logic                   s_b,
    output logic [(1<<N_IN)-1:0]   table_a,
    output logic [(1<<N_IN)-1:0]   table_b,
    output logic                   busy,
    output logic                   done,
    output logic                   equal,
    output logic                   mismatch_valid,
    output logic [N_IN-1:0]        first_mismatch
);

    localparam int              c_table_w   = 1 << N_IN;
    localparam logic [3:0]      c_hold_last = 4'(SETTLE);
    localparam logic [N_IN-1:0] c_idx_last  = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    state_t                r_state;
    logic [N_IN-1:0]       r_idx;      // also drives vec_o directly
    logic [3:0]            r_hold;
    logic [c_table_w-1:0]  r_table_a;
    logic [c_table_w-1:0]  r_table_b;
    logic                  r_equal;
    logic                  r_mm_valid;
    logic [N_IN-1:0]       r_mm_idx;

    // ------------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------------
    state_t                w_state_nxt;
    logic [N_IN-1:0]       w_idx_nxt;
    logic [3:0]            w_hold_nxt;
    logic [c_table_w-1:0]  w_table_a_nxt;
    logic [c_table_w-1:0]  w_table_b_nxt;
    logic                  w_equal_nxt;
    logic                  w_mm_valid_nxt;
    logic [N_IN-1:0]       w_mm_idx_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_hold     <= '0;
            r_table_a  <= '0;
            r_table_b  <= '0;
            r_equal    <= 1'b0;
            r_mm_valid <= 1'b0;
            r_mm_idx   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_hold     <= w_hold_nxt;
            r_table_a  <= w_table_a_nxt;
            r_table_b  <= w_table_b_nxt;
            r_equal    <= w_equal_nxt;
            r_mm_valid <= w_mm_valid_nxt;
            r_mm_idx   <= w_mm_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_hold_nxt     = r_hold;
        w_table_a_nxt  = r_table_a;
        w_table_b_nxt  = r_table_b;
        w_equal_nxt    = r_equal;
        w_mm_valid_nxt = r_mm_valid;
        w_mm_idx_nxt   = r_mm_idx;

        case (r_state)
            ST_IDLE: begin
                // Results from the previous scan are held here until a new
                // scan is accepted, at which point everything is cleared.
                if (start) begin
                    w_state_nxt    = ST_SCAN;
                    w_idx_nxt      = '0;
                    w_hold_nxt     = '0;
                    w_table_a_nxt  = '0;
                    w_table_b_nxt  = '0;
                    w_equal_nxt    = 1'b0;
                    w_mm_valid_nxt = 1'b0;
                    w_mm_idx_nxt   = '0;
                end
            end

            ST_SCAN: begin
                if (r_hold == c_hold_last) begin
                    // Capture edge: the only point at which s_a/s_b matter,
                    // so glitches during the settle window are ignored.
                    w_table_a_nxt[r_idx] = s_a;
                    w_table_b_nxt[r_idx] = s_b;

                    // Indices are visited in ascending order, so the first
                    // recorded difference is automatically the lowest one.
                    if ((s_a != s_b) && !r_mm_valid) begin
                        w_mm_valid_nxt = 1'b1;
                        w_mm_idx_nxt   = r_idx;
                    end

                    if (r_idx == c_idx_last) begin
                        // Compare using the tables including this final bit,
                        // so equal is already correct during the done cycle.
                        w_state_nxt = ST_DONE;
                        w_equal_nxt = (w_table_a_nxt == w_table_b_nxt);
                    end else begin
                        w_idx_nxt  = r_idx + 1'b1;
                        w_hold_nxt = '0;
                    end
                end else begin
                    w_hold_nxt = r_hold + 4'd1;
                end
            end

            ST_DONE: begin
                // vec_o keeps its last value; start is not looked at here.
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign vec_o          = r_idx;
    assign table_a        = r_table_a;
    assign table_b        = r_table_b;
    assign busy           = (r_state == ST_SCAN);
    assign done           = (r_state == ST_DONE);
    assign equal          = r_equal;
    assign mismatch_valid = r_mm_valid;
    assign first_mismatch = r_mm_idx;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_scanner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_truth_table_scanner
// Description : Self-checking bench for truth_table_scanner. Instance u_dut1
//               (SETTLE=1) is checked through an expected-result queue that
//               a done-driven monitor drains; instance u_dut0 (SETTLE=0) is
//               used for cycle-by-cycle stimulus sequencing checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_scanner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start1 = 1'b0;
    logic       start0 = 1'b0;
    int         mode = 0;

    logic [2:0] vec1, vec0, fm1, fm0;
    logic       sa1, sb1, sa0, sb0;
    logic [7:0] ta1, tb1, ta0, tb0;
    logic       busy1, done1, eq1, mv1;
    logic       busy0, done0, eq0, mv0;

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;

    typedef struct {
        logic [7:0] ta;
        logic [7:0] tb;
        logic       eq;
        logic       mv;
        logic [2:0] fm;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    // Reference function: zeros at indices 3, 4, 5 -> table 8'hC7.
    function automatic logic f_a(input logic [2:0] v);
        logic x, y, z;
        x = v[2]; y = v[1]; z = v[0];
        return (x | ~y | ~z) & (~x | y | ~z) & (~x | y | z);
    endfunction

    function automatic logic f_b(input logic [2:0] v, input int m);
        logic x, y, z;
        x = v[2]; y = v[1]; z = v[0];
        case (m)
            0:       return (~x | y) & (x | ~y | ~z);
            1:       return 1'b1;
            2:       return 1'b0;
            default: return f_a(v) ^ (v == 3'd7);
        endcase
    endfunction

    assign sa1 = f_a(vec1);
    assign sb1 = f_b(vec1, mode);
    assign sa0 = f_a(vec0);
    assign sb0 = f_b(vec0, 0);

    truth_table_scanner #(.N_IN(3), .SETTLE(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .vec_o(vec1),
        .s_a(sa1), .s_b(sb1), .table_a(ta1), .table_b(tb1),
        .busy(busy1), .done(done1), .equal(eq1),
        .mismatch_valid(mv1), .first_mismatch(fm1)
    );

    truth_table_scanner #(.N_IN(3), .SETTLE(0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .vec_o(vec0),
        .s_a(sa0), .s_b(sb0), .table_a(ta0), .table_b(tb0),
        .busy(busy0), .done(done0), .equal(eq0),
        .mismatch_valid(mv0), .first_mismatch(fm0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every done on u_dut1 consumes one expected result.
    always @(negedge clk) begin
        if (reset) begin
            busy_cnt = 0;
        end else begin
            if (busy1) busy_cnt++;
            if (done1) begin
                chk("busy_len", busy_cnt, 16);
                chk("busy_at_done", {31'd0, busy1}, 0);
                busy_cnt = 0;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=done expected=no_done");
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("table_a", {24'd0, ta1}, {24'd0, e.ta});
                    chk("table_b", {24'd0, tb1}, {24'd0, e.tb});
                    chk("equal", {31'd0, eq1}, {31'd0, e.eq});
                    chk("mismatch_valid", {31'd0, mv1}, {31'd0, e.mv});
                    chk("first_mismatch", {29'd0, fm1}, {29'd0, e.fm});
                end
            end
        end
    end

    task automatic pulse1();
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
    endtask

    task automatic wait_done1();
        int n = 0;
        while (!done1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!done1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no_done expected=done");
        end
    endtask

    task automatic push(input logic [7:0] ta, input logic [7:0] tb,
                        input logic eq, input logic mv, input logic [2:0] fm);
        exp_t e;
        e.ta = ta; e.tb = tb; e.eq = eq; e.mv = mv; e.fm = fm;
        q.push_back(e);
    endtask

    task automatic chk_zero1(input string tag);
        chk({tag, "_vec"},   {29'd0, vec1}, 0);
        chk({tag, "_ta"},    {24'd0, ta1}, 0);
        chk({tag, "_tb"},    {24'd0, tb1}, 0);
        chk({tag, "_busy"},  {31'd0, busy1}, 0);
        chk({tag, "_done"},  {31'd0, done1}, 0);
        chk({tag, "_eq"},    {31'd0, eq1}, 0);
        chk({tag, "_mv"},    {31'd0, mv1}, 0);
        chk({tag, "_fm"},    {29'd0, fm1}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        // Reset state
        repeat (3) @(posedge clk);
        #1 chk_zero1("reset");
        reset = 1'b0;

        // Equivalent implementations
        mode = 0;
        push(8'hC7, 8'hC7, 1'b1, 1'b0, 3'd0);
        pulse1();
        wait_done1();
        repeat (3) @(negedge clk);
        chk("hold_equal", {31'd0, eq1}, 1);
        chk("hold_table_a", {24'd0, ta1}, 32'hC7);

        // s_b tied high: first difference at index 3
        mode = 1;
        push(8'hC7, 8'hFF, 1'b0, 1'b1, 3'd3);
        pulse1();
        @(negedge clk);
        chk("start_clears_equal", {31'd0, eq1}, 0);
        chk("start_clears_table", {24'd0, ta1}, 0);
        wait_done1();

        // s_b tied low: first difference at index 0
        mode = 2;
        push(8'hC7, 8'h00, 1'b0, 1'b1, 3'd0);
        pulse1();
        wait_done1();

        // Only the terminal index differs
        mode = 3;
        push(8'hC7, 8'h47, 1'b0, 1'b1, 3'd7);
        pulse1();
        wait_done1();

        // Reset asserted mid-scan while vec_o == 5
        mode = 0;
        push(8'hC7, 8'hC7, 1'b1, 1'b0, 3'd0);
        pulse1();
        n = 0;
        while (vec1 != 3'd5 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reach_vec5", {29'd0, vec1}, 5);
        #1 reset = 1'b1;
        #1 chk_zero1("async_reset");
        q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        push(8'hC7, 8'hC7, 1'b1, 1'b0, 3'd0);
        pulse1();
        wait_done1();

        // start pulsed during a scan is ignored
        push(8'hC7, 8'hC7, 1'b1, 1'b0, 3'd0);
        pulse1();
        repeat (4) @(posedge clk);
        #1 start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        wait_done1();
        repeat (20) @(posedge clk);

        // start held for 40 edges: scans accepted on edges 1, 19 and 37
        repeat (3) push(8'hC7, 8'hC7, 1'b1, 1'b0, 3'd0);
        @(posedge clk);
        #1 start1 = 1'b1;
        repeat (40) @(posedge clk);
        #1 start1 = 1'b0;
        n = 0;
        while ((q.size() != 0 || busy1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("backtoback_drained", q.size(), 0);

        // Stimulus sequencing on the SETTLE=0 instance
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("seq_busy", {31'd0, busy0}, 1);
            chk("seq_vec", {29'd0, vec0}, k);
        end
        @(negedge clk);
        chk("seq_done", {31'd0, done0}, 1);
        chk("seq_busy_low", {31'd0, busy0}, 0);
        chk("seq_table", {24'd0, ta0}, 32'hC7);
        chk("seq_equal", {31'd0, eq0}, 1);
        chk("seq_vec_hold", {29'd0, vec0}, 7);
        @(negedge clk);
        chk("seq_done_width", {31'd0, done0}, 0);

        repeat (5) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
